// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types, constants and the round-robin search helper
// for the AXI-Stream round-robin arbiter. The optional stats build is
// selected with AXIS_ARB_STATS_EN (see axis_rr_arbiter).

package axis_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of the optional per-requester accepted-beat counters.
  localparam int ARB_CNT_WIDTH = 16;

  // Largest requester count the helper below can handle.
  localparam int ARB_MAX_REQ = 16;

  // Round-robin search over the low n bits of valid, starting at ptr+1
  // and wrapping modulo n. The request vector is doubled, rotated down
  // so the start position lands at bit 0, priority-encoded from bit 0,
  // and the offset is rotated back by adding the start index.
  // Returns {found, idx[3:0]}.
  function automatic logic [4:0] rr_next(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  n);
    logic [15:0] mask;
    logic [15:0] vm;
    logic [31:0] dbl;
    logic [15:0] rot;
    logic [4:0]  nxt;
    logic [4:0]  start;
    logic [4:0]  off;
    logic [4:0]  idx;
    logic        found;

    // n = 16 makes the shifted one fall off, leaving an all-ones mask.
    mask  = (16'd1 << n) - 16'd1;
    vm    = valid & mask;
    nxt   = {1'b0, ptr} + 5'd1;
    start = (nxt >= n) ? 5'd0 : nxt;
    dbl   = {16'd0, vm} | ({16'd0, vm} << n);
    rot   = 16'(dbl >> start) & mask;

    // Descending scan so the lowest set bit (nearest to start) wins.
    found = 1'b0;
    off   = 5'd0;
    for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 5'(i);
      end
    end

    idx = start + off;
    if (idx >= n) begin
      idx = idx - n;
    end
    return {found, idx[3:0]};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Finds the first set bit of req
// at or after ptr+1 (wrapping). One instance serves both the idle pick and
// the end-of-packet handover pick in axis_rr_arbiter.

module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  logic [4:0] res;

  // Rotate-priority-rotate-back search via the shared package helper.
  always_comb begin
    res   = rr_next(16'(req), 4'(ptr), 5'(NUM_REQ));
    found = res[4];
    idx   = ID_WIDTH'(res[3:0]);
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locking round-robin arbiter sharing one AXI-Stream
// sink among NUM_REQ requesters. A grant is held from the first beat of a
// packet until its last beat is accepted; m_id tags every beat with its
// source. Defining AXIS_ARB_STATS_EN adds per-requester 16-bit accepted-beat
// counters readable through cnt_sel/cnt_out.
//
//   state    | meaning
//   ARB_IDLE | no grant held, all outputs 0
//   ARB_BUSY | grant held by requester gnt_q

module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  output logic [ID_WIDTH-1:0]           m_id,
  input  logic                          m_ready
`ifdef AXIS_ARB_STATS_EN
  ,
  input  logic [ID_WIDTH-1:0]           cnt_sel,
  output logic [ARB_CNT_WIDTH-1:0]      cnt_out
`endif
);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d;
  logic [ID_WIDTH-1:0] last_gnt_q, last_gnt_d;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                beat_acc;

  // last_gnt equals gnt while busy, so the same pointer serves the idle
  // search (from last_gnt+1) and the handover search (from gnt+1).
  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (s_valid),
    .ptr   (last_gnt_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign beat_acc = m_valid & m_ready;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Next-state: grab a winner when idle; on the accepted last beat either
  // hand over without a bubble or drop back to idle. The granted
  // requester's own valid takes part in the handover search, so a lone
  // streaming requester is re-granted back-to-back.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BUSY;
          gnt_d      = pick_idx;
          last_gnt_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (beat_acc && m_last) begin
          if (pick_found) begin
            gnt_d      = pick_idx;
            last_gnt_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Datapath mux: forward the granted requester; everything is 0 when idle.
  // s_ready depends only on m_ready and the registered grant.
  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_id    = '0;
    s_ready = '0;
    if (state_q == ARB_BUSY) begin
      m_data  = s_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
      m_valid = s_valid[gnt_q];
      m_last  = s_last[gnt_q];
      m_id    = gnt_q;
      s_ready = {{(NUM_REQ-1){1'b0}}, m_ready} << gnt_q;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [ARB_CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  // Accepted-beat counters, one per requester, wrapping at all-ones.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (beat_acc) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + 1'b1;
    end
  end

  // Counter readback; selects beyond NUM_REQ-1 read as 0.
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NUM_REQ) begin
      cnt_out = cnt_q[cnt_sel];
    end
  end
`endif

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin, packet-locking arbiter that shares one AXI-Stream sink, typically the slave port of `fifo_axi`, among `NUM_REQ` AXI-Stream requesters. It sits directly in front of the FIFO. Each grant is held from the first beat of a packet until its `last` beat is accepted, so packets from different requesters never interleave in the FIFO. A `m_id` sideband identifies the source of every beat.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: payload width per beat.
- `NUM_REQ`, default 4: number of requesters; legal range 2–16.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: width of the grant index and of `m_id`.

Ports:
- `aclk` input 1: single clock; all logic on its rising edge.
- `aresetn` input 1: reset, asynchronous and active-low.
- `s_data` input `NUM_REQ*DATA_WIDTH`: requester payloads; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_valid` input `NUM_REQ`: per-requester valid.
- `s_last` input `NUM_REQ`: per-requester end-of-packet marker.
- `s_ready` output `NUM_REQ`: per-requester ready; one-hot or zero.
- `m_data` output `DATA_WIDTH`: payload to the FIFO.
- `m_valid` output 1: valid to the FIFO.
- `m_last` output 1: end-of-packet to the FIFO.
- `m_id` output `ID_WIDTH`: index of the granted requester.
- `m_ready` input 1: FIFO ready, i.e. `s_ready` of `fifo_axi`.

## Operation
- FSM states:
  - `IDLE`: no grant held.
  - `BUSY`: grant held by requester `gnt`.
- Round-robin pointer `last_gnt`: the search starts at `last_gnt+1` and wraps modulo `NUM_REQ`. The first requester found with `s_valid` set wins.
- IDLE → BUSY:
  - Trigger: any bit of `s_valid` is set.
  - `gnt` is loaded with the winner.
  - `last_gnt` is loaded with the winner.
- While in BUSY:
  - `m_data = s_data[gnt]`, `m_valid = s_valid[gnt]`, `m_last = s_last[gnt]`, `m_id = gnt`.
  - `s_ready[gnt] = m_ready`; all other `s_ready` bits are 0.
- Beat accepted: `m_valid && m_ready`.
- Beat accepted with `m_last = 1`:
  - If any other or the same requester is valid that cycle, the arbiter picks the next winner from `gnt+1` and stays in BUSY. This gives a zero-bubble handover.
  - Otherwise the arbiter goes to IDLE.
- Requesters drop valid freely; `m_valid` simply follows. There is no timeout. A requester that stalls mid-packet holds the grant indefinitely.
- In IDLE, all outputs are forced to 0.
- Reset, asynchronous at any time including mid-packet:
  - FSM goes to IDLE, `gnt = 0`, `last_gnt = NUM_REQ-1`, so requester 0 wins first.
  - All outputs go to 0: `s_ready`, `m_valid`, `m_last`, `m_data`, `m_id`.
  - A partial packet already in the FIFO is not repaired. The system resets the FIFO with the same `aresetn`.

## Timing
- Arbitration latency:
  - `s_valid` seen in IDLE in cycle N produces `m_valid` and `s_ready` from cycle N+1.
  - Within BUSY, the path from input to output is combinational, with no added latency.
- `s_ready[gnt]` depends combinationally on `m_ready` only, never on `s_valid`. This is AXI-compliant.
- Back-to-back packets:
  - The last beat of packet A and the first beat of packet B move in consecutive cycles.
  - With all requesters continuously valid, the sustained rate is 1 beat per cycle.
- Single-beat packet (`s_last = 1` on the first beat): the grant releases after one accepted beat.
- FIFO full (`m_ready = 0`): the grant is held and no beat is lost. `m_data`, `m_valid` and `m_last` hold as long as the requester holds.
- Fairness: for `NUM_REQ` continuously valid requesters, each gets exactly one packet per `NUM_REQ` packets.

## Configuration
- `AXIS_ARB_STATS_EN` defined: adds per-requester 16-bit accepted-beat counters.
  - The counters wrap at 0xFFFF → 0 and are cleared by reset.
  - Additional ports: `cnt_sel` input `ID_WIDTH`, and `cnt_out` output 16, driven combinationally as `cnt[cnt_sel]`.
- Macro undefined: no counters and no `cnt_*` ports. All other behaviour is identical.

## Structure
- Package `axis_arb_pkg`:
  - State enum `{ARB_IDLE, ARB_BUSY}`.
  - Function `rr_next(valid, ptr)`.
  - Constant `ARB_CNT_WIDTH = 16`.
- Sub-module `rr_pick`: combinational rotate-priority-rotate-back picker.
  - Inputs: `req[NUM_REQ]`, `ptr[ID_WIDTH]`.
  - Outputs: `found`, `idx`.
  - It is instantiated once and used for both the IDLE and the handover picks.

## Test plan
- **Reset/first grant:** after reset, `s_valid = 4'b1111`, each packet is 2 beats, `m_ready = 1`. Required: `m_id` sequence 0,0,1,1,2,2,3,3,0…; `m_valid` is first set one cycle after `s_valid`.
- **Packet lock:** requester 2 sends 3 beats `0xA0..0xA2` while requester 1 is valid from beat 2. Required: the FIFO receives `A0, A1, A2` before any requester-1 data; `s_ready[1] = 0` throughout.
- **Backpressure/full:** fill `fifo_axi` (depth 16) via requester 0, then hold `m_ready = 0` for 5 cycles mid-packet. Required: `m_data` is stable, no beat is dropped or duplicated, and all 20 written words read back in order.
- **Zero-bubble handover:** requesters 0 and 3 each send single-beat packets continuously. Required: `m_id` alternates 0,3,0,3 with `m_valid` high every cycle.
- **Reset mid-packet:** assert `aresetn = 0` on beat 2 of a 4-beat packet. Required: all outputs are 0 within the same cycle; after release, requester 0 is granted first.
- **Stats (with `AXIS_ARB_STATS_EN`):** send 70000 beats from requester 1. Required: `cnt_out` with `cnt_sel = 1` reads 70000 mod 65536 = 4464; the other counters read 0.
